// File: rtl/mod_reduce_seq.sv
// Sequential a mod m: MSB-first restoring long division, one operand bit per cycle.
// Optional MOD_REDUCE_FASTPATH_EN: an operand already below m completes at accept.
module mod_reduce_seq #(
  parameter int W  = 256,
  parameter int CW = $clog2(2*W)+1
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           start,
  input  logic [2*W-1:0] a,
  input  logic [W-1:0]   m,
  output logic           ready,
  output logic           done,
  output logic [W-1:0]   result,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [2*W-1:0] a_q, a_d;
  logic [W-1:0]   m_q, m_d;
  logic [W-1:0]   r_q, r_d;   // R < M always holds, so the top bit of the W+1 remainder is never set
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   result_q, result_d;
  logic           err_q, err_d;
  logic [W:0]     t;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    m_d      = m_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    err_d    = err_q;
    t        = {r_q, a_q[2*W-1]};
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = a;
          m_d   = m;
          r_d   = '0;
          cnt_d = '0;
          err_d = 1'b0;
          if (m == '0) begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = DONE;
          end
`ifdef MOD_REDUCE_FASTPATH_EN
          else if (a < {{W{1'b0}}, m}) begin
            result_d = a[W-1:0];
            state_d  = DONE;
          end
`endif
          else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = W'((t >= {1'b0, m_q}) ? t - {1'b0, m_q} : t);
        a_d   = a_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(2*W-1)) begin
          result_d = r_d;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      m_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      m_q      <= m_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign err    = err_q;

endmodule
